rom_16x8: RTL and testbench



---
 rtl/rom_pkg.sv | 34 +++
 rtl/rom_16x8.sv | 39 +++
 tb/tb_rom_16x8.sv | 103 ++++++++++
 3 files changed

// File: rtl/rom_pkg.sv
// Shared types and the fixed 16x8 content image for rom_16x8.
// Each word holds its own index in the high nibble and the index's complement in the low nibble.
package rom_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    typedef logic [ADDR_W-1:0] rom_addr_t;
    typedef logic [DATA_W-1:0] rom_data_t;

    function automatic rom_data_t rom_word(input rom_addr_t a);
        rom_data_t w;
        case (a)
            4'h0:    w = 8'h0F;
            4'h1:    w = 8'h1E;
            4'h2:    w = 8'h2D;
            4'h3:    w = 8'h3C;
            4'h4:    w = 8'h4B;
            4'h5:    w = 8'h5A;
            4'h6:    w = 8'h69;
            4'h7:    w = 8'h78;
            4'h8:    w = 8'h87;
            4'h9:    w = 8'h96;
            4'hA:    w = 8'hA5;
            4'hB:    w = 8'hB4;
            4'hC:    w = 8'hC3;
            4'hD:    w = 8'hD2;
            4'hE:    w = 8'hE1;
            default: w = 8'hF0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rom_16x8.sv
// Synchronous-read 16x8 constant ROM; one-cycle read latency, output registered and held while idle.
// No flow control: a read is accepted on every enabled edge.
module rom_16x8 #(
    parameter int          ADDR_W  = 4,
    parameter int          DATA_W  = 8,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] outdata
);
    import rom_pkg::*;

    if (ADDR_W != rom_pkg::ADDR_W) begin : g_bad_addr_w
        $error("rom_16x8: only ADDR_W=4 is supported");
    end
    if (DATA_W != rom_pkg::DATA_W) begin : g_bad_data_w
        $error("rom_16x8: only DATA_W=8 is supported");
    end

    rom_data_t w_rd_dat;
    rom_data_t r_outdata;

    assign w_rd_dat = rom_word(rom_addr_t'(addr));

    // Reset wins over a read on the same edge; a disabled edge holds the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outdata <= RST_VAL;
        end else if (enable) begin
            r_outdata <= w_rd_dat;
        end
    end

    assign outdata = r_outdata;

endmodule

// File: tb/tb_rom_16x8.sv
// Directed and randomized checks of rom_16x8 against an arithmetic model of the content image.
module tb_rom_16x8;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [3:0] addr;
    logic [7:0] outdata;

    int n_checks = 0;
    int n_fail   = 0;

    rom_16x8 #(.ADDR_W(4), .DATA_W(8), .RST_VAL(8'h00)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .addr    (addr),
        .outdata (outdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word i = high nibble i, low nibble 15-i.
    function automatic logic [7:0] ref_word(input int a);
        return 8'((a * 16) + (15 - a));
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    initial begin
        logic [7:0] exp_q;
        int         r;

        rst = 1'b1; enable = 1'b0; addr = 4'h9;                   // t=0
        #1  chk("reset_t0", outdata, 8'h00);                      // t=1
        #5  chk("reset_edge5", outdata, 8'h00);                   // t=6
        #10 chk("reset_edge15", outdata, 8'h00);                  // t=16
        #4  rst = 1'b0; enable = 1'b1; addr = 4'hB;               // t=20
        #6  chk("read_after_release", outdata, 8'hB4);            // t=26
        #14 rst = 1'b1;                                           // t=40
        #1  chk("async_reset_no_edge", outdata, 8'h00);           // t=41
        #19 rst = 1'b0; enable = 1'b1; addr = 4'h1;               // t=60
        #6  chk("read_after_mid_reset", outdata, 8'h1E);          // t=66
        #14 rst = 1'b1; enable = 1'b1; addr = 4'hF;               // t=80
        #1  chk("rst_dominates_t81", outdata, 8'h00);
        #5  chk("rst_dominates_edge85", outdata, 8'h00);
        #10 chk("rst_dominates_edge95", outdata, 8'h00);          // t=96
        #4  rst = 1'b0; enable = 1'b0; addr = 4'h5;               // t=100
        #6  chk("hold_disabled_105", outdata, 8'h00);
        #10 chk("hold_disabled_115", outdata, 8'h00);             // t=116
        #4  enable = 1'b1; addr = 4'h8;                           // t=120
        #6  chk("read_after_hold", outdata, 8'h87);               // t=126
        #4;                                                       // t=130

        for (int i = 0; i < 16; i++) begin
            enable = 1'b1; addr = 4'(i);
            #6 chk($sformatf("sweep_%0h", i), outdata, ref_word(i));
            #4;
        end

        // Mid-cycle address change must not leak to the output.
        enable = 1'b1; addr = 4'h3;                               // t=290
        #6 chk("mid_cycle_base", outdata, ref_word(3));
        addr = 4'h7;
        #3 chk("mid_cycle_addr_change", outdata, ref_word(3));
        #1 enable = 1'b0;                                         // t=300
        #6 chk("hold_after_mid_change", outdata, ref_word(3));
        #4;                                                       // t=310

        exp_q = ref_word(3);
        for (int k = 0; k < 300; k++) begin
            r      = int'($urandom_range(0, 31));
            enable = 1'($urandom_range(0, 3) != 0);
            addr   = 4'($urandom_range(0, 15));
            rst    = (r == 0);
            if (rst)         exp_q = 8'h00;
            else if (enable) exp_q = ref_word(int'(addr));
            #6 chk($sformatf("rand_%0d", k), outdata, exp_q);
            if (r == 1) begin
                #1 rst = 1'b1;
                exp_q = 8'h00;
                #1 chk($sformatf("rand_async_%0d", k), outdata, exp_q);
                #2;
            end else begin
                #4;
            end
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
